// File: rtl/stoch_encoder_bank_pkg.sv
// Shared constants for the stochastic encoder bank: LFSR geometry, taps, seed and write-port widths.
package stoch_encoder_bank_pkg;

  localparam int unsigned LFSR_W = 16;
  // x^16 + x^15 + x^13 + x^4 + 1 -> state bits 15, 14, 12, 3
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hD008;
  localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 16'hACE1;
  localparam int unsigned IDX_W = 16;
  localparam int unsigned DATA_W = 16;

  function automatic logic [LFSR_W-1:0] rotl(input logic [LFSR_W-1:0] x, input int unsigned sh);
    return LFSR_W'((x << sh) | (x >> (LFSR_W - sh)));
  endfunction

endpackage

// File: rtl/stoch_encoder_bank_if.sv
// Indexed value-write port of the encoder bank (valid/ready with an error pulse).
interface stoch_encoder_bank_if;
  import stoch_encoder_bank_pkg::*;

  logic              wr_valid;
  logic              wr_ready;
  logic [IDX_W-1:0]  wr_index;
  logic [DATA_W-1:0] wr_data;
  logic              wr_err;

  modport master (output wr_valid, output wr_index, output wr_data, input wr_ready, input wr_err);
  modport slave  (input wr_valid, input wr_index, input wr_data, output wr_ready, output wr_err);
endinterface

// File: rtl/stoch_encoder_bank_lfsr16.sv
// 16-bit Fibonacci LFSR with clock enable; the zero state is unreachable from a nonzero seed.
module sng_lfsr16
  import stoch_encoder_bank_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = LFSR_DEFAULT_SEED
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  output logic [LFSR_W-1:0] state_o
);

  logic [LFSR_W-1:0] state_q;
  logic [LFSR_W-1:0] state_d;

  always_comb begin
    state_d = state_q;
    if (en_i) state_d = {state_q[LFSR_W-2:0], ^(state_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= SEED;
    else         state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/stoch_encoder_bank.sv
// Bank of stochastic number generators sharing one LFSR, with double-buffered values
// committed at frame boundaries and the forward-pass frame timer.
module stoch_encoder_bank
  import stoch_encoder_bank_pkg::*;
#(
  parameter int unsigned       N_NODES   = 38,
  parameter int unsigned       DP_in     = 8,
  parameter int unsigned       FRAME_LEN = 256,
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_DEFAULT_SEED
) (
  input  logic                CLK,
  input  logic                RESET_n,
  input  logic                ENABLE,
  stoch_encoder_bank_if.slave wr,
  output logic [N_NODES-1:0]  stream,
  output logic                FP_FRAME,
  output logic                pre_FP_FRAME
);

  localparam int unsigned      CNT_W    = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

  logic [LFSR_W-1:0]  lfsr_state;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DP_in-1:0]   shadow_q [N_NODES];
  logic [DP_in-1:0]   shadow_d [N_NODES];
  logic [DP_in-1:0]   active_q [N_NODES];
  logic [DP_in-1:0]   active_d [N_NODES];
  logic [N_NODES-1:0] stream_q, stream_d;
  logic               fp_q, fp_d;
  logic               pre_q, pre_d;
  logic               ready_q, ready_d;
  logic               err_q, err_d;
  logic               commit_c, wr_fire_c, in_range_c;
  logic [DATA_W-1:0]  wr_data_unused;

  assign wr_data_unused = wr.wr_data;

  sng_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk_i   (CLK),
    .rst_ni  (RESET_n),
    .en_i    (ENABLE),
    .state_o (lfsr_state)
  );

  // Timer, handshake and double-buffer next state. wr_ready is low on the commit
  // cycle, so a write can never race the shadow->active copy.
  always_comb begin
    commit_c   = ENABLE && (cnt_q == CNT_LAST);
    wr_fire_c  = wr.wr_valid && ready_q;
    in_range_c = wr.wr_index < IDX_W'(N_NODES);
    cnt_d      = cnt_q;
    if (ENABLE) cnt_d = commit_c ? '0 : cnt_q + CNT_W'(1);
    fp_d    = commit_c;
    pre_d   = (cnt_d == CNT_LAST);
    ready_d = !pre_d;
    err_d   = wr_fire_c && !in_range_c;
    for (int i = 0; i < N_NODES; i++) begin
      shadow_d[i] = shadow_q[i];
      active_d[i] = commit_c ? shadow_q[i] : active_q[i];
      if (wr_fire_c && (wr.wr_index == IDX_W'(i))) shadow_d[i] = wr.wr_data[DP_in-1:0];
    end
  end

  // Comparators see the committing value on the wrap edge so a new frame starts with new values.
  for (genvar g = 0; g < N_NODES; g++) begin : g_node
    logic [LFSR_W-1:0] rot_c;
    logic [DP_in-1:0]  val_c;
    assign rot_c       = rotl(lfsr_state, 32'(g) % LFSR_W);
    assign val_c       = commit_c ? shadow_q[g] : active_q[g];
    assign stream_d[g] = ENABLE && (val_c > rot_c[LFSR_W-1 -: DP_in]);
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      cnt_q    <= '0;
      shadow_q <= '{default: '0};
      active_q <= '{default: '0};
      stream_q <= '0;
      fp_q     <= 1'b0;
      pre_q    <= 1'b0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      stream_q <= stream_d;
      fp_q     <= fp_d;
      pre_q    <= pre_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
    end
  end

  assign stream       = stream_q;
  assign FP_FRAME     = fp_q;
  assign pre_FP_FRAME = pre_q;
  assign wr.wr_ready  = ready_q;
  assign wr.wr_err    = err_q;

endmodule

// File: doc/stoch_encoder_bank.md
# stoch_encoder_bank

Bank of stochastic number generators: converts per-node DP_in-bit decimal values, loaded over an indexed write port, into one stochastic bitstream per node by comparing against a shared LFSR. Owns the forward-pass frame timer and generates FP_FRAME / pre_FP_FRAME for the network. It is the encode end of the chain whose decode end is the MEAN-counter bank. Loaded values are double-buffered and take effect only at frame boundaries.

## Interface
- N_NODES, 38, number of encoded nodes / bitstreams
- DP_in, 8, value precision in bits (1..16)
- FRAME_LEN, 256, cycles per forward-pass frame (2..65535)
- LFSR_SEED, 16'hACE1, nonzero LFSR reset seed
- CLK  in  1  sole clock, rising edge
- RESET_n  in  1  asynchronous active-low reset
- ENABLE  in  1  run control; low freezes timer and LFSR
- wr_valid  in  1  write request
- wr_ready  out  1  write accept; transfer when wr_valid & wr_ready
- wr_index  in  16  node index of write
- wr_data  in  16  value; bits [DP_in-1:0] used, upper bits ignored
- wr_err  out  1  one-cycle pulse: accepted write had wr_index >= N_NODES
- stream  out  N_NODES  stochastic bits, one per node
- FP_FRAME  out  1  high on first cycle of each frame
- pre_FP_FRAME  out  1  high on last cycle of each frame

## Operation
- Reset: shadow[] and active[] = 0, LFSR = LFSR_SEED, cnt = 0; stream = 0, FP_FRAME = 0, pre_FP_FRAME = 0, wr_ready = 0, wr_err = 0. All outputs registered.
- LFSR: 16-bit Fibonacci, taps x^16+x^15+x^13+x^4+1, shifts once per cycle when ENABLE=1; never reaches 0.
- Per-node random: rnd_i = top DP_in bits of (LFSR rotated left by i mod 16).
- stream[i] <= (active[i] > rnd_i) when ENABLE=1; 0 when ENABLE=0. value 0 gives all-zero stream.
- Frame timer cnt: 0..FRAME_LEN-1, increments when ENABLE=1, wraps to 0.
- Commit: on the edge where cnt wraps (FRAME_LEN-1 -> 0) with ENABLE=1, active[] <= shadow[] (all nodes atomically).
- Write: accepted write sets shadow[wr_index] <= wr_data[DP_in-1:0]; out-of-range index changes nothing, wr_err pulses next cycle.
- wr_ready = 1 out of reset except in cycles where cnt == FRAME_LEN-1 and ENABLE=1 (commit cycle); a write presented then is stalled one cycle and lands in the next frame's shadow.
- Multiple writes to the same index within a frame: last one wins.
- ENABLE low mid-frame: cnt, LFSR, active[] hold; writes still accepted; resumes exactly where paused.
- RESET_n low mid-frame: immediate return to reset state; shadow contents lost.

## Timing
- Write-to-stream latency: value written in frame k appears in stream from the first cycle of frame k+1 (cycle where FP_FRAME=1).
- FP_FRAME registered: high for the single cycle after the wrap edge, i.e. the cycle cnt == 0 following a wrap; not asserted in the first frame after reset.
- pre_FP_FRAME high for the single cycle cnt == FRAME_LEN-1 (ENABLE=1); FP_FRAME follows it next enabled cycle.
- stream[i] in cycle t uses active[] and LFSR state from cycle t-1 (one-register latency).
- wr_ready low exactly the cycle pre_FP_FRAME is high.
- Over 65535 consecutive enabled cycles (full LFSR period), DP_in=8: ones count on stream[i] = 256*v - 1 for v >= 1, 0 for v = 0.

## Structure
- Shared package: LFSR polynomial/tap constant, LFSR width (16), default seed, wr_index width (16).
- One sub-module: sng_lfsr16 (LFSR with enable, seed parameter); comparators, shadow/active arrays and frame timer stay in the top.

## Test plan
- Reset held, then released: all outputs 0 through reset; wr_ready = 1 first cycle after release; FP_FRAME first seen after FRAME_LEN enabled cycles.
- FRAME_LEN=65535, write node 3 = 255, node 5 = 0, node 7 = 128: over the next full frame ones counts are 65279, 0, 32767 respectively.
- Write node 2 = 64 in frame k: stream[2] stays 0 through frame k, nonzero from the FP_FRAME cycle of frame k+1.
- Write presented on pre_FP_FRAME cycle: wr_ready low, accepted next cycle, effective only in frame k+2.
- Write wr_index = 38 (N_NODES=38): accepted, wr_err pulses one cycle, no stream changes.
- ENABLE low for 10 cycles mid-frame: stream = 0, cnt/LFSR frozen; frame boundary delayed by exactly 10 cycles; assert RESET_n mid-frame -> all outputs 0 immediately.
